// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and the default build point of the pin-level FIFO wrapper.
package sync_fifo_pkg;

  localparam int TT_WIDTH     = 4;
  localparam int TT_DEPTH     = 3;
  localparam int TT_AF_THRESH = TT_DEPTH - 1;
  localparam int TT_AE_THRESH = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A one-entry-wide pointer still needs one bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH storage array: synchronous write port, asynchronous read port, no reset.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and a choice of registered or fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 3,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 0,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int            PW       = ptr_width(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths cycle 0..DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_q == CNT_MAX);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wptr_d = wr_acc ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = rd_acc ? ptr_inc(rptr_q) : rptr_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error event in the clearing cycle keeps the flag set.
    overflow_d  = (wr_en & full)  | (overflow_q  & ~clr_err);
    underflow_d = (rd_en & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  if (FWFT == 0) begin : g_reg_read
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
      rdata_d  = rd_acc ? mem_rdata : rdata_q;
      rvalid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rdata_q  <= rdata_d;
        rvalid_q <= rvalid_d;
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_fwft_read
    assign rdata  = mem_rdata;
    assign rvalid = ~empty;
  end

endmodule
